// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan decoder.
// Holds the glyph table constants, FSM state type, bus widths and
// small helpers for inspecting the active-low anode select vector.
package seg_pkg;

  localparam int unsigned NUM_DIGITS_DEFAULT = 8;
  localparam int unsigned SEG_W              = 7;
  localparam int unsigned AN_W               = 8;
  localparam int unsigned CNT_W              = 8;
  localparam int unsigned NIB_W              = 4;
  localparam int unsigned VALUE_W            = 32;

  // Active-low abcdefg patterns (bit6 = a ... bit0 = g)
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_0   = 7'b0000001;
  localparam logic [SEG_W-1:0] GLYPH_1   = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_2   = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_3   = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_4   = 7'b1001100;
  localparam logic [SEG_W-1:0] GLYPH_5   = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_6   = 7'b1100000;
  localparam logic [SEG_W-1:0] GLYPH_7   = 7'b0001111;
  localparam logic [SEG_W-1:0] GLYPH_8   = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9   = 7'b0001100;
  localparam logic [SEG_W-1:0] GLYPH_A   = 7'b1110010;
  localparam logic [SEG_W-1:0] GLYPH_B   = 7'b1100110;
  localparam logic [SEG_W-1:0] GLYPH_C   = 7'b1011100;
  localparam logic [SEG_W-1:0] GLYPH_D   = 7'b0110100;
  localparam logic [SEG_W-1:0] GLYPH_E   = 7'b1110000;
  localparam logic [SEG_W-1:0] GLYPH_F   = SEG_BLANK;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } seg_state_e;

  // Number of asserted (low) anode lines
  function automatic logic [3:0] an_low_count(input logic [AN_W-1:0] an);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < int'(AN_W); i++) begin
      if (!an[i]) n = n + 4'd1;
    end
    return n;
  endfunction

  // Position of the asserted anode line (meaningful only when one-hot)
  function automatic logic [2:0] an_index(input logic [AN_W-1:0] an);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < int'(AN_W); i++) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder.
//   seg_n    : active-low abcdefg segment pattern
//   nibble_c : decoded hex value (0 for unknown patterns)
//   legal_c  : 1 when the pattern is one of the 16 known glyphs
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg_n,
  output logic [NIB_W-1:0] nibble_c,
  output logic             legal_c
);

  always_comb begin
    nibble_c = '0;
    legal_c  = 1'b1;
    case (seg_n)
      GLYPH_0: nibble_c = 4'h0;
      GLYPH_1: nibble_c = 4'h1;
      GLYPH_2: nibble_c = 4'h2;
      GLYPH_3: nibble_c = 4'h3;
      GLYPH_4: nibble_c = 4'h4;
      GLYPH_5: nibble_c = 4'h5;
      GLYPH_6: nibble_c = 4'h6;
      GLYPH_7: nibble_c = 4'h7;
      GLYPH_8: nibble_c = 4'h8;
      GLYPH_9: nibble_c = 4'h9;
      GLYPH_A: nibble_c = 4'hA;
      GLYPH_B: nibble_c = 4'hB;
      GLYPH_C: nibble_c = 4'hC;
      GLYPH_D: nibble_c = 4'hD;
      GLYPH_E: nibble_c = 4'hE;
      GLYPH_F: nibble_c = 4'hF;
      default: legal_c  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the value shown on a multiplexed seven-segment display by
// watching its segment and anode lines, and reports complete frames.
// Optional feature macro: SEG_DP_CAPTURE_EN (capture decimal points).
//   clk, rst_n  : clock, async active-low reset
//   seg_n       : segment lines, active-low, bit6=a .. bit0=g
//   an_n        : anode selects, active-low, bit k selects digit k
//   dp_n        : decimal point line, active-low
//   value       : last complete frame, nibble k = digit k
//   dp_out      : last complete frame decimal points (1 = lit)
//   frame_valid : one-cycle pulse when value/dp_out update
//   frame_err   : sticky error flag, re-evaluated at each frame
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SEG_W-1:0]   seg_n,
  input  logic [AN_W-1:0]    an_n,
  input  logic               dp_n,
  output logic [VALUE_W-1:0] value,
  output logic [AN_W-1:0]    dp_out,
  output logic               frame_valid,
  output logic               frame_err
);

  localparam logic [AN_W-1:0] DIGIT_MASK = AN_W'((32'd1 << NUM_DIGITS) - 32'd1);

  // Synchronizers and previous-sample copy; reset to the idle (all-high) level
  logic [SEG_W-1:0]   seg_s1_q, seg_s2_q, prev_seg_q;
  logic [AN_W-1:0]    an_s1_q, an_s2_q, prev_an_q;
  seg_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AN_W-1:0]    seen_q, seen_d;
  logic [VALUE_W-1:0] shadow_val_q, shadow_val_d;
  logic               gerr_q, gerr_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_err_q, frame_err_d;

  logic [3:0]         low_cnt_c;
  logic [2:0]         idx_c;
  logic               onehot_c, multi_c, same_c, eval_c, settled_c;
  logic               capture_c, an_err_c, complete_c, gerr_next_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic [NIB_W-1:0]   nibble_c;
  logic               legal_c;

`ifdef SEG_DP_CAPTURE_EN
  logic               dp_s1_q, dp_s2_q, prev_dp_q;
  logic [AN_W-1:0]    shadow_dp_q, shadow_dp_d;
  logic [AN_W-1:0]    dp_out_q, dp_out_d;
  logic               dp_same_c;
  assign dp_same_c = (dp_s2_q == prev_dp_q);
  assign dp_out    = dp_out_q;
`else
  logic               unused_dp_n;
  logic               dp_same_c;
  assign unused_dp_n = dp_n;
  assign dp_same_c   = 1'b1;
  assign dp_out      = '0;
`endif

  seg_glyph_decode u_glyph_decode (
    .seg_n    (seg_s2_q),
    .nibble_c (nibble_c),
    .legal_c  (legal_c)
  );

  assign low_cnt_c = an_low_count(an_s2_q);
  assign idx_c     = an_index(an_s2_q);
  assign onehot_c  = (low_cnt_c == 4'd1);
  assign multi_c   = (low_cnt_c > 4'd1);
  assign same_c    = (an_s2_q == prev_an_q) && (seg_s2_q == prev_seg_q) && dp_same_c;
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Next-state: HELD/SETTLE fall into the IDLE evaluation in the same cycle on change
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    eval_c    = 1'b0;
    settled_c = 1'b0;
    an_err_c  = 1'b0;
    case (state_q)
      IDLE:   eval_c = 1'b1;
      SETTLE: begin
        if (same_c) begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CNT_W'(SETTLE_CYC)) begin
            settled_c = 1'b1;
            state_d   = HELD;
          end
        end else begin
          eval_c = 1'b1;
        end
      end
      HELD:    eval_c = !same_c;
      default: state_d = IDLE;
    endcase
    if (eval_c) begin
      if (onehot_c) begin
        state_d = SETTLE;
        cnt_d   = CNT_W'(1);
      end else begin
        state_d  = IDLE;
        an_err_c = multi_c;
      end
    end
  end

  assign capture_c   = settled_c && (32'(idx_c) < NUM_DIGITS);
  assign complete_c  = &(seen_q | ~DIGIT_MASK);
  assign gerr_next_c = gerr_q | (capture_c & ~legal_c);

  // Shadow capture and frame hand-off; a same-cycle capture joins the completing frame
  always_comb begin
    shadow_val_d  = shadow_val_q;
    seen_d        = seen_q;
    gerr_d        = gerr_next_c;
    value_d       = value_q;
    frame_valid_d = 1'b0;
    frame_err_d   = frame_err_q | an_err_c | (capture_c & ~legal_c);
`ifdef SEG_DP_CAPTURE_EN
    shadow_dp_d   = shadow_dp_q;
    dp_out_d      = dp_out_q;
`endif
    if (capture_c) begin
      shadow_val_d[{idx_c, 2'b00} +: NIB_W] = nibble_c;
      seen_d[idx_c] = 1'b1;
`ifdef SEG_DP_CAPTURE_EN
      shadow_dp_d[idx_c] = ~dp_s2_q;
`endif
    end
    if (complete_c) begin
      value_d       = shadow_val_d;
      frame_valid_d = 1'b1;
      seen_d        = '0;
      gerr_d        = 1'b0;
      frame_err_d   = gerr_next_c | an_err_c;
`ifdef SEG_DP_CAPTURE_EN
      dp_out_d      = shadow_dp_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q      <= '1;
      seg_s2_q      <= '1;
      prev_seg_q    <= '1;
      an_s1_q       <= '1;
      an_s2_q       <= '1;
      prev_an_q     <= '1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      seen_q        <= '0;
      shadow_val_q  <= '0;
      gerr_q        <= 1'b0;
      value_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
      dp_s1_q       <= 1'b1;
      dp_s2_q       <= 1'b1;
      prev_dp_q     <= 1'b1;
      shadow_dp_q   <= '0;
      dp_out_q      <= '0;
`endif
    end else begin
      seg_s1_q      <= seg_n;
      seg_s2_q      <= seg_s1_q;
      prev_seg_q    <= seg_s2_q;
      an_s1_q       <= an_n;
      an_s2_q       <= an_s1_q;
      prev_an_q     <= an_s2_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      shadow_val_q  <= shadow_val_d;
      gerr_q        <= gerr_d;
      value_q       <= value_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
`ifdef SEG_DP_CAPTURE_EN
      dp_s1_q       <= dp_n;
      dp_s2_q       <= dp_s1_q;
      prev_dp_q     <= dp_s2_q;
      shadow_dp_q   <= shadow_dp_d;
      dp_out_q      <= dp_out_d;
`endif
    end
  end

  assign value       = value_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans digits through the display
// lines and compares recovered frames against hand-computed values.
module tb_seg_scan_decoder;

  localparam int unsigned SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [7:0]  an_n;
  logic        dp_n;
  logic [31:0] value;
  logic [7:0]  dp_out;
  logic        frame_valid;
  logic        frame_err;

  int n_vec  = 0;
  int n_bad  = 0;
  int fv_cnt = 0;
  int base;
  logic [31:0] fv_value = '0;
  logic        fv_err   = 1'b0;
  logic [7:0]  fv_dp    = '0;
  logic [7:0]  dp_exp;

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b1100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b1110010, 7'b1100110,
    7'b1011100, 7'b0110100, 7'b1110000, 7'b1111111
  };

  seg_scan_decoder #(.SETTLE_CYC(SETTLE), .NUM_DIGITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .dp_n        (dp_n),
    .value       (value),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Record every frame pulse and the outputs presented with it
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_cnt   <= fv_cnt + 1;
      fv_value <= value;
      fv_err   <= frame_err;
      fv_dp    <= dp_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int idx, input logic [6:0] seg, input logic dp, input int hold);
    an_n  = ~(8'(1) << idx);
    seg_n = seg;
    dp_n  = ~dp;
    tick(hold);
  endtask

  task automatic blank(input int n);
    an_n  = '1;
    seg_n = '1;
    dp_n  = 1'b1;
    tick(n);
  endtask

  // Show the selected digits of val in order; short_idx gets one sample too few
  task automatic scan(input logic [31:0] val, input logic [7:0] dpm, input logic [7:0] which,
                      input int short_idx, input int hold);
    for (int k = 0; k < 8; k++) begin
      if (which[k])
        show(k, glyph[val[4*k +: 4]], dpm[k], (k == short_idx) ? SETTLE - 1 : hold);
    end
    blank(10);
  endtask

  task automatic do_reset();
    an_n  = '1;
    seg_n = '1;
    dp_n  = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

  initial begin
    rst_n = 1'b0;
    an_n  = '1;
    seg_n = '1;
    dp_n  = 1'b1;
    #12;
    check("rst_value", value, 32'h0);
    check("rst_dp_out", 32'(dp_out), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    blank(3);
    check("idle_no_err", 32'(frame_err), 32'h0);

    // Basic scan 1..8
    base = fv_cnt;
    scan(32'h87654321, 8'h00, 8'hFF, -1, 20);
    check("basic_count", 32'(fv_cnt - base), 32'd1);
    check("basic_value", fv_value, 32'h87654321);
    check("basic_err", 32'(fv_err), 32'h0);
    check("basic_dp", 32'(fv_dp), 32'h0);
    check("basic_pulse_low", 32'(frame_valid), 32'h0);

    // Every digit held exactly SETTLE samples; covers remaining glyphs
    do_reset();
    base = fv_cnt;
    scan(32'h0FEDCBA9, 8'h00, 8'hFF, -1, SETTLE);
    check("exact_hold_count", 32'(fv_cnt - base), 32'd1);
    check("exact_hold_value", fv_value, 32'h0FEDCBA9);

    // Digit 3 one sample short, then a full scan
    do_reset();
    base = fv_cnt;
    scan(32'h76543210, 8'h00, 8'hFF, 3, 20);
    check("short_no_frame", 32'(fv_cnt - base), 32'd0);
    scan(32'h76543210, 8'h00, 8'hFF, -1, 20);
    check("short_then_full", 32'(fv_cnt - base), 32'd1);
    check("short_full_value", fv_value, 32'h76543210);

    // Illegal glyph on digit 5, then a clean frame
    do_reset();
    base = fv_cnt;
    for (int k = 0; k < 8; k++)
      show(k, (k == 5) ? 7'b1111110 : glyph[k + 1], 1'b0, 20);
    blank(10);
    check("illegal_count", 32'(fv_cnt - base), 32'd1);
    check("illegal_value", fv_value, 32'h87054321);
    check("illegal_fv_err", 32'(fv_err), 32'h1);
    check("illegal_sticky", 32'(frame_err), 32'h1);
    scan(32'h87654321, 8'h00, 8'hFF, -1, 20);
    check("clean_count", 32'(fv_cnt - base), 32'd2);
    check("clean_fv_err", 32'(fv_err), 32'h0);
    check("clean_err", 32'(frame_err), 32'h0);

    // Two anodes low at once
    do_reset();
    base  = fv_cnt;
    an_n  = 8'b11110011;
    seg_n = glyph[1];
    tick(10);
    blank(5);
    check("multi_err", 32'(frame_err), 32'h1);
    scan(32'h87654321, 8'h00, 8'hF3, -1, 20);
    check("multi_no_capture", 32'(fv_cnt - base), 32'd0);
    scan(32'h87654321, 8'h00, 8'h0C, -1, 20);
    check("multi_then_frame", 32'(fv_cnt - base), 32'd1);
    check("multi_value", fv_value, 32'h87654321);
    check("multi_err_cleared", 32'(frame_err), 32'h0);

    // Reset after four digits of a second frame
    do_reset();
    base = fv_cnt;
    scan(32'h87654321, 8'h00, 8'hFF, -1, 20);
    check("prefr_count", 32'(fv_cnt - base), 32'd1);
    for (int k = 0; k < 4; k++)
      show(k, glyph[k + 5], 1'b0, 20);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_value", value, 32'h0);
    check("midrst_dp_out", 32'(dp_out), 32'h0);
    check("midrst_err", 32'(frame_err), 32'h0);
    an_n  = '1;
    seg_n = '1;
    tick(2);
    rst_n = 1'b1;
    blank(3);
    base = fv_cnt;
    scan(32'h12345678, 8'h00, 8'hF0, -1, 20);
    check("midrst_partial", 32'(fv_cnt - base), 32'd0);
    scan(32'h12345678, 8'h00, 8'h0F, -1, 20);
    check("midrst_rescan", 32'(fv_cnt - base), 32'd1);
    check("midrst_new_value", fv_value, 32'h12345678);

    // Decimal points on digits 0 and 7
    do_reset();
    base = fv_cnt;
    scan(32'h87654321, 8'h81, 8'hFF, -1, 20);
`ifdef SEG_DP_CAPTURE_EN
    dp_exp = 8'h81;
`else
    dp_exp = 8'h00;
`endif
    check("dp_count", 32'(fv_cnt - base), 32'd1);
    check("dp_frame", 32'(fv_dp), 32'(dp_exp));
    check("dp_out_held", 32'(dp_out), 32'(dp_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
